// File: rtl/beep_arbiter_if.sv
// Bus bundle for beep_arbiter: request strobes and per-requester beep counts
// in, burst status and the buzzer drive out. The master side belongs to
// whoever raises requests, and the slave side belongs to the arbiter.
interface beep_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [3*NREQ-1:0] req_beeps;
    logic              busy;
    logic [2:0]        grant_id;
    logic              done;
    logic [NREQ-1:0]   pending;
    logic              beep;

    modport master (
        output req, req_beeps,
        input  busy, grant_id, done, pending, beep
    );

    modport slave (
        input  req, req_beeps,
        output busy, grant_id, done, pending, beep
    );
endinterface

// File: rtl/beep_arbiter.sv
// beep_arbiter: shares one buzzer between NREQ requesters. Request pulses are
// latched as pending and served by fixed priority, with index 0 highest. Each
// grant plays a burst of 1..7 tone beeps, and silent gaps separate the beeps.
// The square-wave tone is generated here, so beep can go straight to the pin.
// Optional macro BEEP_PREEMPT_EN: a pending request with higher priority aborts
// the burst in progress during ON or GAP.
module beep_arbiter #(
    parameter int NREQ      = 4,
    parameter int ON_CYC    = 12_500_000,
    parameter int GAP_CYC   = 6_250_000,
    parameter int TONE_HALF = 12_500
) (
    input  logic           clk,
    input  logic           rstn,
    beep_arbiter_if.slave  bus
);

    localparam int DUR_MAX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int DUR_W   = $clog2(DUR_MAX + 1);
    localparam int TONE_W  = $clog2(TONE_HALF + 1);

    localparam logic [DUR_W-1:0]  ON_LAST   = DUR_W'(ON_CYC - 1);
    localparam logic [DUR_W-1:0]  GAP_LAST  = DUR_W'(GAP_CYC - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

    typedef enum logic [1:0] {IDLE, ON, GAP, FIN} state_t;

    state_t            state, state_nx;
    logic [DUR_W-1:0]  dur, dur_nx;
    logic [TONE_W-1:0] tone, tone_nx;
    logic [2:0]        remaining, remaining_nx;
    logic [2:0]        grant_id, grant_nx;
    logic [NREQ-1:0]   pending, pending_nx, grant_clr;
    logic              busy, busy_nx;
    logic              done, done_nx;
    logic              beep, beep_nx;

    logic              sel_valid;
    logic [2:0]        sel_idx;
    logic [2:0]        sel_beeps;

`ifdef BEEP_PREEMPT_EN
    logic [NREQ-1:0]   higher_mask;
`endif

    // Pick the lowest-numbered pending requester together with its beep count.
    always_comb begin
        sel_valid = |pending;
        sel_idx   = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = 3'(i);
            end
        end
        sel_beeps = bus.req_beeps[int'(sel_idx) * 3 +: 3];
    end

`ifdef BEEP_PREEMPT_EN
    // Mark the requesters that outrank the one being served.
    always_comb begin
        higher_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            higher_mask[i] = (3'(i) < grant_id);
        end
    end
`endif

    // Burst sequencer: next state, the duration and tone counters, and the tone level.
    always_comb begin
        state_nx     = state;
        dur_nx       = dur;
        tone_nx      = tone;
        remaining_nx = remaining;
        grant_nx     = grant_id;
        grant_clr    = '0;
        beep_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (sel_valid) begin
                    grant_nx     = sel_idx;
                    remaining_nx = (sel_beeps == 3'd0) ? 3'd1 : sel_beeps;
                    grant_clr    = NREQ'(1) << sel_idx;
                    dur_nx       = '0;
                    tone_nx      = '0;
                    state_nx     = ON;
                end
            end
            ON: begin
                if (dur == ON_LAST) begin
                    dur_nx       = '0;
                    tone_nx      = '0;
                    remaining_nx = remaining - 3'd1;
                    state_nx     = (remaining == 3'd1) ? FIN : GAP;
                end else begin
                    dur_nx = dur + 1'b1;
                    if (tone == TONE_LAST) begin
                        tone_nx = '0;
                        beep_nx = ~beep;
                    end else begin
                        tone_nx = tone + 1'b1;
                        beep_nx = beep;
                    end
                end
            end
            GAP: begin
                if (dur == GAP_LAST) begin
                    dur_nx   = '0;
                    tone_nx  = '0;
                    state_nx = ON;
                end else begin
                    dur_nx = dur + 1'b1;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

`ifdef BEEP_PREEMPT_EN
        if ((state == ON || state == GAP) && |(pending & higher_mask)) begin
            state_nx     = IDLE;
            dur_nx       = '0;
            tone_nx      = '0;
            remaining_nx = 3'd0;
            beep_nx      = 1'b0;
        end
`endif

        // A new request in the same cycle as the grant wins, so the requester is re-queued.
        pending_nx = (pending & ~grant_clr) | bus.req;
        busy_nx    = (state_nx != IDLE);
        done_nx    = (state_nx == FIN);
    end

    // Register the state, the counters and every output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            dur       <= '0;
            tone      <= '0;
            remaining <= 3'd0;
            grant_id  <= 3'd0;
            pending   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            beep      <= 1'b0;
        end else begin
            state     <= state_nx;
            dur       <= dur_nx;
            tone      <= tone_nx;
            remaining <= remaining_nx;
            grant_id  <= grant_nx;
            pending   <= pending_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            beep      <= beep_nx;
        end
    end

    assign bus.busy     = busy;
    assign bus.grant_id = grant_id;
    assign bus.done     = done;
    assign bus.pending  = pending;
    assign bus.beep     = beep;

endmodule
